// File: rtl/uart_ctrl_pkg.sv
// Shared constants and state encoding for the UART command/response sequencer.
package uart_ctrl_pkg;

  localparam int unsigned CMD_DEPTH_DEF      = 32;
  localparam int unsigned RSP_DEPTH_DEF      = 32;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 5000000;
  localparam logic [7:0]  TERM_CR            = 8'h0D;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TX_LOAD  = 3'd1,
    S_TX_START = 3'd2,
    S_TX_HOLD  = 3'd3,
    S_TX_WAIT  = 3'd4,
    S_RX_WAIT  = 3'd5,
    S_DONE     = 3'd6
  } seq_state_e;

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// Byte-level link between the sequencer and the UART wrapper.
interface uart_cmd_sequencer_if;
  logic       tx_start;
  logic [7:0] txd;
  logic       tx_busy;
  logic [7:0] rxd;
  logic       rx_valid;

  modport master (output tx_start, txd, input tx_busy, rxd, rx_valid);
  modport slave  (input tx_start, txd, output tx_busy, rxd, rx_valid);
endinterface

// File: rtl/uart_byte_buf.sv
// Byte buffer with one write port and a registered (1-cycle latency) read port.
module uart_byte_buf #(
  parameter  int unsigned DEPTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Sends a buffered ASCII command plus terminator over the UART, then captures
// the response until the terminator or an inter-byte timeout.
module uart_cmd_sequencer
  import uart_ctrl_pkg::*;
#(
  parameter  int unsigned CMD_DEPTH      = CMD_DEPTH_DEF,
  parameter  int unsigned RSP_DEPTH      = RSP_DEPTH_DEF,
  parameter  int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter  logic [7:0]  TERM           = TERM_CR,
  localparam int unsigned CAW            = $clog2(CMD_DEPTH),
  localparam int unsigned RAW            = $clog2(RSP_DEPTH),
  localparam int unsigned TOW            = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_wr,
  input  logic [7:0]            cmd_wdata,
  input  logic                  cmd_go,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic                  rsp_overflow,
  output logic [RAW:0]          rsp_len,
  input  logic [RAW-1:0]        rsp_raddr,
  output logic [7:0]            rsp_rdata,
  uart_cmd_sequencer_if.master  uart
);

  localparam logic [CAW:0]   CMD_FULL = (CAW+1)'(CMD_DEPTH);
  localparam logic [RAW:0]   RSP_FULL = (RAW+1)'(RSP_DEPTH);
  localparam logic [TOW-1:0] TO_LAST  = TOW'(TIMEOUT_CYCLES - 1);

  seq_state_e     state;
  logic [CAW:0]   cmd_len;
  logic [CAW:0]   tx_idx;
  logic           send_term;
  logic [TOW-1:0] to_cnt;
  logic [7:0]     cmd_rdata;
  logic           cmd_we;
  logic           rsp_we;

  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);
  assign cmd_we = (state == S_IDLE) && cmd_wr && (cmd_len != CMD_FULL);
  assign rsp_we = (state == S_RX_WAIT) && uart.rx_valid && (uart.rxd != TERM)
                  && (rsp_len != RSP_FULL);

  // tx_idx may equal CMD_DEPTH when only the terminator remains; the wrapped
  // address is harmless because send_term selects TERM instead of buffer data.
  uart_byte_buf #(.DEPTH(CMD_DEPTH)) u_cmd_buf (
    .clk   (clk),
    .we    (cmd_we),
    .waddr (cmd_len[CAW-1:0]),
    .wdata (cmd_wdata),
    .raddr (tx_idx[CAW-1:0]),
    .rdata (cmd_rdata)
  );

  uart_byte_buf #(.DEPTH(RSP_DEPTH)) u_rsp_buf (
    .clk   (clk),
    .we    (rsp_we),
    .waddr (rsp_len[RAW-1:0]),
    .wdata (uart.rxd),
    .raddr (rsp_raddr),
    .rdata (rsp_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cmd_len       <= '0;
      tx_idx        <= '0;
      send_term     <= 1'b0;
      to_cnt        <= '0;
      rsp_len       <= '0;
      timeout       <= 1'b0;
      rsp_overflow  <= 1'b0;
      uart.tx_start <= 1'b0;
      uart.txd      <= '0;
    end else begin
      uart.tx_start <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_we) cmd_len <= cmd_len + 1'b1;
          if (cmd_go) begin
            timeout      <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_len      <= '0;
            tx_idx       <= '0;
            state        <= S_TX_LOAD;
          end
        end
        S_TX_LOAD: begin
          send_term <= (tx_idx == cmd_len);
          state     <= S_TX_START;
        end
        S_TX_START: begin
          if (!uart.tx_busy) begin
            uart.tx_start <= 1'b1;
            uart.txd      <= send_term ? TERM : cmd_rdata;
            state         <= S_TX_HOLD;
          end
        end
        S_TX_HOLD: state <= S_TX_WAIT;
        S_TX_WAIT: begin
          if (!uart.tx_busy) begin
            if (send_term) begin
              to_cnt <= '0;
              state  <= S_RX_WAIT;
            end else begin
              tx_idx <= tx_idx + 1'b1;
              state  <= S_TX_LOAD;
            end
          end
        end
        S_RX_WAIT: begin
          // A byte arriving on the expiry cycle wins over the timeout.
          if (uart.rx_valid) begin
            to_cnt <= '0;
            if (uart.rxd == TERM)      state        <= S_DONE;
            else if (rsp_len == RSP_FULL) rsp_overflow <= 1'b1;
            else                       rsp_len      <= rsp_len + 1'b1;
          end else if (to_cnt == TO_LAST) begin
            timeout <= 1'b1;
            state   <= S_DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_DONE: begin
          cmd_len <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer with a simple transmitter model.
module tb_uart_cmd_sequencer;

  localparam int unsigned CMD_D = 8;
  localparam int unsigned RSP_D = 8;
  localparam int unsigned TO_C  = 100;
  localparam int          TX_BUSY_CYCLES = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_wr;
  logic [7:0] cmd_wdata;
  logic       cmd_go;
  logic       busy, done, timeout, rsp_overflow;
  logic [3:0] rsp_len;
  logic [2:0] rsp_raddr;
  logic [7:0] rsp_rdata;

  uart_cmd_sequencer_if u_if ();

  uart_cmd_sequencer #(
    .CMD_DEPTH      (CMD_D),
    .RSP_DEPTH      (RSP_D),
    .TIMEOUT_CYCLES (TO_C),
    .TERM           (8'h0D)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_wr       (cmd_wr),
    .cmd_wdata    (cmd_wdata),
    .cmd_go       (cmd_go),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .rsp_overflow (rsp_overflow),
    .rsp_len      (rsp_len),
    .rsp_raddr    (rsp_raddr),
    .rsp_rdata    (rsp_rdata),
    .uart         (u_if)
  );

  always #5 clk = ~clk;

  // Transmitter model: captures each started byte, stays busy for a while.
  int         busy_cnt   = 0;
  int         tx_overlap = 0;
  logic [7:0] txq [$];

  assign u_if.tx_busy = (busy_cnt != 0);

  always @(posedge clk) begin
    #1;
    if (u_if.tx_start) begin
      if (u_if.tx_busy) tx_overlap++;
      txq.push_back(u_if.txd);
      busy_cnt = TX_BUSY_CYCLES;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] q_at(input int i);
    if (i < txq.size()) return txq[i];
    return 8'hxx;
  endfunction

  task automatic wr(input logic [7:0] b);
    cmd_wr = 1'b1; cmd_wdata = b;
    @(negedge clk);
    cmd_wr = 1'b0;
  endtask

  task automatic go();
    cmd_go = 1'b1;
    @(negedge clk);
    cmd_go = 1'b0;
  endtask

  task automatic rx(input logic [7:0] b);
    u_if.rxd = b; u_if.rx_valid = 1'b1;
    @(negedge clk);
    u_if.rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic rx_term(input string tag);
    u_if.rxd = 8'h0D; u_if.rx_valid = 1'b1;
    @(negedge clk);
    u_if.rx_valid = 1'b0;
    chk({tag, "_done_pulse"}, done, 1);
    @(negedge clk);
    chk({tag, "_done_clear"}, {done, busy}, 0);
  endtask

  task automatic rd(input int a, output logic [7:0] v);
    rsp_raddr = 3'(a);
    @(negedge clk);
    v = rsp_rdata;
  endtask

  // Waits for n captured bytes and for the transmitter to go idle again.
  task automatic wait_tx(input int n, input string tag);
    int c = 0;
    while (txq.size() < n && c < 2000) begin @(negedge clk); c++; end
    while (u_if.tx_busy && c < 2000) begin @(negedge clk); c++; end
    chk({tag, "_tx_in_time"}, (c < 2000), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int n;
    logic [7:0] ver [4];
    logic [7:0] rsp [4];
    ver = '{8'h3F, 8'h56, 8'h45, 8'h52};
    rsp = '{8'h56, 8'h31, 8'h2E, 8'h32};

    rst_n = 1'b0; cmd_wr = 1'b0; cmd_wdata = '0; cmd_go = 1'b0; rsp_raddr = '0;
    u_if.rxd = '0; u_if.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {busy, done, timeout, rsp_overflow, u_if.tx_start}, 0);
    chk("reset_txd", u_if.txd, 0);
    chk("reset_rsp_len", rsp_len, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // "?VER" command with "V1.2\r" response
    for (int i = 0; i < 4; i++) wr(ver[i]);
    go();
    n = 0;
    while (!u_if.tx_start && n < 50) begin @(negedge clk); n++; end
    chk("go_to_tx_start", n, 2);
    chk("first_txd", u_if.txd, 8'h3F);
    cmd_wr = 1'b1; cmd_wdata = 8'h5A; cmd_go = 1'b1;
    u_if.rxd = 8'h41; u_if.rx_valid = 1'b1;
    @(negedge clk);
    cmd_wr = 1'b0; cmd_go = 1'b0; u_if.rx_valid = 1'b0;
    chk("busy_during_tx", busy, 1);
    wait_tx(5, "ver");
    chk("ver_tx_count", txq.size(), 5);
    for (int i = 0; i < 4; i++) chk($sformatf("ver_txd%0d", i), q_at(i), ver[i]);
    chk("ver_txd_term", q_at(4), 8'h0D);
    chk("tx_start_only_when_idle", tx_overlap, 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) rx(rsp[i]);
    rx_term("ver");
    chk("ver_rsp_len", rsp_len, 4);
    chk("ver_flags", {timeout, rsp_overflow}, 0);
    for (int i = 0; i < 4; i++) begin
      rd(i, v);
      chk($sformatf("ver_rsp%0d", i), v, rsp[i]);
    end

    // rx traffic while idle is dropped
    rx(8'h41);
    rx(8'h0D);
    chk("idle_rx_state", {busy, done}, 0);
    chk("idle_rx_len", rsp_len, 4);
    rd(0, v);
    chk("idle_rx_buf", v, 8'h56);

    // empty command, no response -> timeout
    txq.delete();
    go();
    wait_tx(1, "to");
    n = 0;
    while (!done && n < 500) begin @(negedge clk); n++; end
    chk("to_done_latency", n, TO_C + 1);
    chk("to_tx_count", txq.size(), 1);
    chk("to_txd", q_at(0), 8'h0D);
    chk("to_timeout", timeout, 1);
    chk("to_rsp_len", rsp_len, 0);
    @(negedge clk);
    chk("to_sticky", {busy, timeout}, 2'b01);

    // response longer than the buffer
    txq.delete();
    go();
    wait_tx(1, "ovf");
    repeat (2) @(negedge clk);
    for (int i = 0; i < RSP_D + 3; i++) rx(8'(8'h30 + i));
    rx_term("ovf");
    chk("ovf_rsp_len", rsp_len, RSP_D);
    chk("ovf_flags", {rsp_overflow, timeout}, 2'b10);
    for (int i = 0; i < RSP_D; i++) begin
      rd(i, v);
      chk($sformatf("ovf_rsp%0d", i), v, 8'(8'h30 + i));
    end

    // reset while waiting on the transmitter
    txq.delete();
    wr(8'h41); wr(8'h42);
    go();
    n = 0;
    while (!u_if.tx_busy && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("rst_tx_busy_seen", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_tx_outs", {busy, done, timeout, rsp_overflow, u_if.tx_start}, 0);
    chk("rst_tx_txd", u_if.txd, 0);
    chk("rst_tx_rsp_len", rsp_len, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // reset while collecting a response
    txq.delete();
    go();
    wait_tx(1, "rstrx");
    repeat (2) @(negedge clk);
    rx(8'h55); rx(8'h66);
    chk("rst_rx_partial_len", rsp_len, 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_rx_outs", {busy, done, u_if.tx_start}, 0);
    chk("rst_rx_rsp_len", rsp_len, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // fresh transaction after reset
    txq.delete();
    wr(8'h3F);
    go();
    wait_tx(2, "post");
    chk("post_tx_count", txq.size(), 2);
    chk("post_txd0", q_at(0), 8'h3F);
    chk("post_txd1", q_at(1), 8'h0D);
    repeat (2) @(negedge clk);
    rx_term("post");
    chk("post_rsp_len", rsp_len, 0);
    chk("post_timeout", timeout, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
